dpram_access_arbiter: RTL and testbench
=======================================

Name: dpram_access_arbiter

Overview:
- Shares a simple dual-port RAM (one write port, one read port, one-cycle registered read) between two write requesters and two read requesters.
- Uses a valid/ready handshake per requester with round-robin arbitration, independently on the write and read sides.
- Drives the RAM's write and read controls and returns read data with a requester tag.
- Prevents same-address write/read collisions by holding off the read for one cycle.

Parameters:
- DATA_WIDTH, 4, RAM word width
- ADDR_WIDTH, 4, RAM address width (depth = 2**ADDR_WIDTH)

Ports:
- clk  input  1  single clock for the arbiter and the attached RAM (both RAM ports on clk)
- reset_n  input  1  asynchronous active-low reset
- w0_valid, w1_valid  input  1  write request from requester 0 / 1
- w0_ready, w1_ready  output  1  write grant; transfer when valid && ready
- w0_addr, w1_addr  input  ADDR_WIDTH  write address
- w0_data, w1_data  input  DATA_WIDTH  write data
- r0_valid, r1_valid  input  1  read request from requester 0 / 1
- r0_ready, r1_ready  output  1  read grant
- r0_addr, r1_addr  input  ADDR_WIDTH  read address
- ram_we  output  1  RAM write enable
- ram_waddr  output  ADDR_WIDTH  RAM write address
- ram_din  output  DATA_WIDTH  RAM write data
- ram_re  output  1  RAM read enable
- ram_raddr  output  ADDR_WIDTH  RAM read address
- ram_dout  input  DATA_WIDTH  RAM registered read data, valid 1 cycle after ram_re
- rsp_valid  output  1  read response valid
- rsp_id  output  1  requester that issued the responded read
- rsp_data  output  DATA_WIDTH  read data (equals ram_dout)

Behaviour:
- Clock and reset:
  - Single clock domain.
  - reset_n low asynchronously clears wr_prio = 0, rd_prio = 0, rsp_valid = 0, rsp_id = 0.
  - While reset_n is low, all *_ready, ram_we and ram_re = 0.
- Handshake rules:
  - Requester holds valid, addr and data stable until it sees ready.
  - Ready and the RAM controls are combinational from the valids and the prio registers. There is no wait state.
- Write arbitration:
  - One valid: that requester is granted.
  - Both valid: requester wr_prio is granted.
  - After a grant to requester k: wr_prio <= ~k.
  - No grant: wr_prio holds.
  - ram_we = any write grant; ram_waddr/ram_din come from the granted requester.
  - ram_waddr/ram_din = 0 when idle.
- Read arbitration:
  - Same round-robin scheme using rd_prio, giving the candidate read grant.
  - Collision rule: if ram_we = 1 and the candidate read address == ram_waddr, the read grant is suppressed that cycle. Both r*_ready = 0, ram_re = 0, rd_prio unchanged.
  - The read issues the next cycle and returns the newly written data.
  - A different-address read and a write proceed in the same cycle.
- Response:
  - Cycle after a read grant: rsp_valid = 1, rsp_id = granted requester, rsp_data = ram_dout.
  - Otherwise rsp_valid = 0 and rsp_id holds.
  - Back-to-back reads give back-to-back responses (throughput 1 per cycle). There is no response backpressure.
- Reset mid-operation:
  - A read granted in the cycle before reset asserts produces no response (rsp_valid cleared).
  - A write already committed to the RAM is not undone.
- Address wrap: addresses are used as-is; the full range 0..2**ADDR_WIDTH-1 is legal.
- Implementation: registered state is only wr_prio, rd_prio and the response pipe (valid + id).

Test Plan:
- Reset: hold reset_n = 0 with all valids high -> all readys, ram_we, ram_re and rsp_valid = 0. Release -> w0 granted first (wr_prio = 0).
- Write contention: w0 and w1 valid for 4 cycles (addr 1/2, data A/B) -> grants alternate 0,1,0,1. RAM holds mem[1] = A, mem[2] = B.
- Single write requester: only w1 valid for 3 cycles -> w1_ready = 1 every cycle with no bubbles. Then both valid -> w0 granted.
- Read round-robin: mem[3] = 5, mem[4] = 9; r0 addr 3 and r1 addr 4 both valid for 2 cycles -> responses (id 0, data 5) then (id 1, data 9) on consecutive cycles, each 1 cycle after its grant.
- Collision: mem[7] = 2; same cycle w0 writes addr 7 data C and r1 reads addr 7 -> r1_ready = 0 in cycle N, granted in N+1, response data C in N+2. Repeat with read addr 6 -> read granted in cycle N.
- Reset mid-read: assert reset_n low right after an r0 grant -> no rsp_valid pulse. rsp_valid = 0 and prio returns to 0 after release.

Source files
------------

// File: rtl/dpram_access_arbiter.sv
// Round-robin write/read arbiter for a 1W/1R RAM with a one-cycle registered read.
// Grants are combinational, and a read that would hit the address being written is held off for one cycle.
module dpram_access_arbiter #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  w0_valid,
  output logic                  w0_ready,
  input  logic [ADDR_WIDTH-1:0] w0_addr,
  input  logic [DATA_WIDTH-1:0] w0_data,
  input  logic                  w1_valid,
  output logic                  w1_ready,
  input  logic [ADDR_WIDTH-1:0] w1_addr,
  input  logic [DATA_WIDTH-1:0] w1_data,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data
);

  logic                  wr_prio;
  logic                  rd_prio;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  r_cand0;
  logic                  r_cand1;
  logic                  r_gnt0;
  logic                  r_gnt1;
  logic                  collide;
  logic [ADDR_WIDTH-1:0] cand_addr;

  // Write side: round robin; the bus is zeroed when no requester is granted.
  always_comb begin
    w_gnt0    = reset_n && w0_valid && (!w1_valid || !wr_prio);
    w_gnt1    = reset_n && w1_valid && (!w0_valid || wr_prio);
    ram_we    = w_gnt0 || w_gnt1;
    ram_waddr = '0;
    ram_din   = '0;
    if (w_gnt0) begin
      ram_waddr = w0_addr;
      ram_din   = w0_data;
    end else if (w_gnt1) begin
      ram_waddr = w1_addr;
      ram_din   = w1_data;
    end
  end

  // Read side: a candidate hitting the address being written waits a cycle so it sees the new data.
  always_comb begin
    r_cand0   = reset_n && r0_valid && (!r1_valid || !rd_prio);
    r_cand1   = reset_n && r1_valid && (!r0_valid || rd_prio);
    cand_addr = r_cand1 ? r1_addr : r0_addr;
    collide   = ram_we && (r_cand0 || r_cand1) && (cand_addr == ram_waddr);
    r_gnt0    = r_cand0 && !collide;
    r_gnt1    = r_cand1 && !collide;
    ram_re    = r_gnt0 || r_gnt1;
    ram_raddr = '0;
    if (r_gnt0) begin
      ram_raddr = r0_addr;
    end else if (r_gnt1) begin
      ram_raddr = r1_addr;
    end
  end

  always_comb begin
    w0_ready = w_gnt0;
    w1_ready = w_gnt1;
    r0_ready = r_gnt0;
    r1_ready = r_gnt1;
    rsp_data = ram_dout;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_prio   <= 1'b0;
      rd_prio   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
    end else begin
      if (ram_we) begin
        wr_prio <= w_gnt0;
      end
      if (ram_re) begin
        rd_prio <= r_gnt0;
        rsp_id  <= r_gnt1;
      end
      rsp_valid <= ram_re;
    end
  end

endmodule

// File: tb/tb_dpram_access_arbiter.sv
// Bench for dpram_access_arbiter: a behavioural RAM, directed stimulus, and a response scoreboard.
module tb_dpram_access_arbiter;

  localparam int DW = 4;
  localparam int AW = 4;

  logic          clk;
  logic          reset_n;
  logic          w0_valid, w1_valid, r0_valid, r1_valid;
  logic          w0_ready, w1_ready, r0_ready, r1_ready;
  logic [AW-1:0] w0_addr, w1_addr, r0_addr, r1_addr;
  logic [DW-1:0] w0_data, w1_data;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          rsp_valid, rsp_id;
  logic [DW-1:0] rsp_data;

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    int            cyc;
  } rsp_t;

  rsp_t          sb_q[$];
  logic [DW-1:0] mem [2**AW];
  int            cyc;
  int            errors;
  int            checks;

  dpram_access_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .w0_valid(w0_valid), .w0_ready(w0_ready), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_valid(w1_valid), .w1_ready(w1_ready), .w1_addr(w1_addr), .w1_data(w1_data),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_din(ram_din),
    .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_dout(ram_dout),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM: one write port, one registered read port.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (ram_we) mem[ram_waddr] <= ram_din;
    if (ram_re) ram_dout <= mem[ram_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Each response is compared against the oldest expectation, including its arrival cycle.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        rsp_t e;
        e = sb_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
        chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input logic id, input logic [DW-1:0] data);
    rsp_t e;
    e.id   = id;
    e.data = data;
    e.cyc  = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic idle_all();
    w0_valid = 1'b0; w1_valid = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    ram_dout = '0;
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    reset_n  = 1'b0;
    w0_valid = 1'b1; w1_valid = 1'b1; r0_valid = 1'b1; r1_valid = 1'b1;
    w0_addr = 4'd1; w0_data = 4'hA; w1_addr = 4'd2; w1_data = 4'hB;
    r0_addr = 4'd3; r1_addr = 4'd4;

    // Reset held with every valid asserted: nothing may be granted.
    #2;
    chk("rst_w0_ready", 32'(w0_ready), 32'd0);
    chk("rst_w1_ready", 32'(w1_ready), 32'd0);
    chk("rst_r0_ready", 32'(r0_ready), 32'd0);
    chk("rst_r1_ready", 32'(r1_ready), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_re", 32'(ram_re), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_hold_we", 32'(ram_we), 32'd0);
    chk("rst_hold_rsp", 32'(rsp_valid), 32'd0);

    // Release into write contention: grants must alternate 0,1,0,1.
    next_cycle();
    reset_n = 1'b1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wc_w0_ready", 32'(w0_ready), 32'(i % 2 == 0));
      chk("wc_w1_ready", 32'(w1_ready), 32'(i % 2 == 1));
      chk("wc_ram_we", 32'(ram_we), 32'd1);
      chk("wc_waddr", 32'(ram_waddr), (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("wc_din", 32'(ram_din), (i % 2 == 0) ? 32'hA : 32'hB);
      next_cycle();
    end

    // Lone w1 requester: granted every cycle; afterwards w0 wins contention.
    w0_valid = 1'b0;
    w1_addr = 4'd5; w1_data = 4'h6;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("single_w1_ready", 32'(w1_ready), 32'd1);
      next_cycle();
    end
    chk("mem1", 32'(mem[1]), 32'hA);
    chk("mem2", 32'(mem[2]), 32'hB);
    chk("mem5", 32'(mem[5]), 32'h6);
    w0_valid = 1'b1; w0_addr = 4'd8; w0_data = 4'h1;
    @(negedge clk);
    chk("after_single_w0", 32'(w0_ready), 32'd1);
    chk("after_single_w1", 32'(w1_ready), 32'd0);
    next_cycle();

    // Read round robin with back-to-back responses.
    idle_all();
    mem[3] = 4'd5;
    mem[4] = 4'd9;
    r0_valid = 1'b1; r0_addr = 4'd3;
    r1_valid = 1'b1; r1_addr = 4'd4;
    @(negedge clk);
    chk("rr_r0_ready", 32'(r0_ready), 32'd1);
    chk("rr_r1_ready", 32'(r1_ready), 32'd0);
    chk("rr_raddr0", 32'(ram_raddr), 32'd3);
    if (r0_ready) expect_rsp(1'b0, 4'd5);
    next_cycle();
    @(negedge clk);
    chk("rr2_r0_ready", 32'(r0_ready), 32'd0);
    chk("rr2_r1_ready", 32'(r1_ready), 32'd1);
    if (r1_ready) expect_rsp(1'b1, 4'd9);
    next_cycle();
    idle_all();
    next_cycle();

    // Same-address collision: read held one cycle, then returns the new data.
    mem[7] = 4'd2;
    w0_valid = 1'b1; w0_addr = 4'd7; w0_data = 4'hC;
    r1_valid = 1'b1; r1_addr = 4'd7;
    @(negedge clk);
    chk("col_we", 32'(ram_we), 32'd1);
    chk("col_r1_ready", 32'(r1_ready), 32'd0);
    chk("col_ram_re", 32'(ram_re), 32'd0);
    next_cycle();
    w0_valid = 1'b0;
    @(negedge clk);
    chk("col_next_r1_ready", 32'(r1_ready), 32'd1);
    if (r1_ready) expect_rsp(1'b1, 4'hC);
    next_cycle();
    idle_all();
    next_cycle();

    // Different address: read and write proceed together.
    mem[6] = 4'd4;
    w0_valid = 1'b1; w0_addr = 4'd7; w0_data = 4'h3;
    r1_valid = 1'b1; r1_addr = 4'd6;
    @(negedge clk);
    chk("nocol_we", 32'(ram_we), 32'd1);
    chk("nocol_r1_ready", 32'(r1_ready), 32'd1);
    chk("nocol_raddr", 32'(ram_raddr), 32'd6);
    if (r1_ready) expect_rsp(1'b1, 4'd4);
    next_cycle();
    idle_all();
    next_cycle();

    // Reset right after an r0 grant: no response, priorities back to 0.
    r0_valid = 1'b1; r0_addr = 4'd3;
    @(negedge clk);
    chk("mid_r0_ready", 32'(r0_ready), 32'd1);
    next_cycle();
    reset_n = 1'b0;
    idle_all();
    @(negedge clk);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    next_cycle();
    reset_n = 1'b1;
    w0_valid = 1'b1; w1_valid = 1'b1; w0_addr = 4'd9; w1_addr = 4'd10;
    r0_valid = 1'b1; r1_valid = 1'b1; r0_addr = 4'd3; r1_addr = 4'd4;
    @(negedge clk);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_rst_w0_ready", 32'(w0_ready), 32'd1);
    chk("post_rst_r0_ready", 32'(r0_ready), 32'd1);
    chk("post_rst_r1_ready", 32'(r1_ready), 32'd0);
    if (r0_ready) expect_rsp(1'b0, 4'd5);
    next_cycle();
    idle_all();
    next_cycle();
    next_cycle();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
